ntt_frame_loader: RTL and testbench

Upstream feeder for ntt_block_radix2_pipelined. It accepts a serial stream of coefficients, one per beat, over a valid/ready handshake. Each coefficient is reduced into [0, Q) and assembled into an N-wide parallel frame in a ping-pong (double) buffer. Each completed frame is presented with a valid, a per-frame NTT/iNTT mode bit and a frame id, so the NTT pipeline can take one frame per valid cycle.

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/ntt_frame_loader_if.sv | 38 +++
 rtl/mod_reduce_once.sv | 29 ++
 rtl/ntt_frame_loader.sv | 111 +++++++++++
 tb/tb_ntt_frame_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pkg
// Brief    : Shared NTT constants, coefficient/frame types and bank state.
// Revision : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int W = 32;
  localparam int N = 8;
  localparam logic [W-1:0] Modulus_Q = 32'd134221489;
  localparam int IDX_W = $clog2(N);

  typedef logic [W-1:0] coef_t;
  typedef coef_t frame_t [0:N-1];

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage
`default_nettype wire

// File: rtl/ntt_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_frame_loader_if
// Brief    : Coefficient stream in, parallel frame out, plus error pulses.
// Revision : 1.0 - initial release
// ============================================================================
interface ntt_frame_loader_if;
  import ntt_pkg::*;

  logic        s_valid;
  logic        s_ready;
  coef_t       s_data;
  logic        s_last;
  logic        s_mode;

  logic        m_valid;
  logic        m_ready;
  frame_t      m_data;
  logic        m_mode;
  logic [7:0]  m_frame_id;

  logic        frame_err;
  logic        range_err;

  // The loader itself
  modport slave (
    input  s_valid, s_data, s_last, s_mode, m_ready,
    output s_ready, m_valid, m_data, m_mode, m_frame_id, frame_err, range_err
  );

  // Whoever feeds beats in and consumes frames
  modport master (
    output s_valid, s_data, s_last, s_mode, m_ready,
    input  s_ready, m_valid, m_data, m_mode, m_frame_id, frame_err, range_err
  );

endinterface
`default_nettype wire

// File: rtl/mod_reduce_once.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduce_once
// Brief    : Single conditional subtract of Q, plus a flag for inputs >= 2Q
//            (which one subtraction cannot bring into range).
// Revision : 1.0 - initial release
// ============================================================================
module mod_reduce_once
  import ntt_pkg::*;
#(
  parameter int               WIDTH   = W,
  parameter logic [WIDTH-1:0] MODULUS = Modulus_Q
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] coef,
  output logic             over_2q
);

  // 2Q held one bit wider so the comparison is exact for any WIDTH
  localparam logic [WIDTH:0] c_two_q = {MODULUS, 1'b0};

  logic w_ge_q;

  assign w_ge_q  = (data >= MODULUS);
  assign coef    = w_ge_q ? (data - MODULUS) : data;
  assign over_2q = ({1'b0, data} >= c_two_q);

endmodule
`default_nettype wire

// File: rtl/ntt_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : ntt_frame_loader
// Brief    : Serial coefficient stream -> N-wide frames through a ping-pong
//            buffer, with per-frame mode and id for the NTT pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_frame_loader
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  ntt_frame_loader_if.slave  bus
);

  frame_t           r_bank_data  [0:1];
  bank_state_e      r_bank_state [0:1];
  logic [1:0]       r_bank_mode;
  logic             r_fill_sel;
  logic             r_issue_sel;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_frame_id;
  logic             r_frame_err;
  logic             r_range_err;

  coef_t            w_coef;
  logic             w_over_2q;
  logic             w_accept;
  logic             w_issue;
  logic             w_at_end;
  logic             w_close;

  mod_reduce_once #(
    .WIDTH   (W),
    .MODULUS (Modulus_Q)
  ) u_reduce (
    .data    (bus.s_data),
    .coef    (w_coef),
    .over_2q (w_over_2q)
  );

  // Outputs are forced to their idle values while reset is held
  assign bus.s_ready    = !reset && (r_bank_state[r_fill_sel] != FULL);
  assign bus.m_valid    = !reset && (r_bank_state[r_issue_sel] == FULL);
  assign bus.m_mode     = !reset && r_bank_mode[r_issue_sel];
  assign bus.m_frame_id = r_frame_id;
  assign bus.frame_err  = !reset && r_frame_err;
  assign bus.range_err  = !reset && r_range_err;

  for (genvar gi = 0; gi < N; gi++) begin : g_mdata
    assign bus.m_data[gi] = reset ? '0 : r_bank_data[r_issue_sel][gi];
  end

  assign w_accept = bus.s_valid && bus.s_ready;
  assign w_issue  = bus.m_valid && bus.m_ready;
  assign w_at_end = (r_idx == IDX_W'(N - 1));
  assign w_close  = w_accept && (bus.s_last || w_at_end);

  // Bank fill/issue bookkeeping; fill and issue always target different
  // banks (one is FULL, the other is not), so both proceed in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        r_bank_state[b] <= EMPTY;
        for (int i = 0; i < N; i++) begin
          r_bank_data[b][i] <= '0;
        end
      end
      r_bank_mode <= '0;
      r_fill_sel  <= 1'b0;
      r_issue_sel <= 1'b0;
      r_idx       <= '0;
      r_frame_id  <= '0;
      r_frame_err <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_range_err <= 1'b0;

      // Zeroing on issue is what makes early-s_last frames zero padded
      if (w_issue) begin
        for (int i = 0; i < N; i++) begin
          r_bank_data[r_issue_sel][i] <= '0;
        end
        r_bank_state[r_issue_sel] <= EMPTY;
        r_bank_mode[r_issue_sel]  <= 1'b0;
        r_issue_sel               <= ~r_issue_sel;
        r_frame_id                <= r_frame_id + 8'd1;
      end

      if (w_accept) begin
        r_bank_data[r_fill_sel][r_idx] <= w_coef;
        r_range_err                    <= w_over_2q;
        if (r_idx == '0) begin
          r_bank_mode[r_fill_sel] <= bus.s_mode;
        end
        if (w_close) begin
          r_bank_state[r_fill_sel] <= FULL;
          r_fill_sel               <= ~r_fill_sel;
          r_idx                    <= '0;
          r_frame_err              <= w_at_end && !bus.s_last;
        end else begin
          r_bank_state[r_fill_sel] <= FILLING;
          r_idx                    <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_frame_loader
// Brief    : Scoreboard bench for ntt_frame_loader with directed beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_frame_loader;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ntt_frame_loader_if bus ();

  ntt_frame_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [N-1:0][W-1:0] data;
    logic                mode;
    logic [7:0]          id;
    logic                ferr;
    logic                rerr;
    logic                timed;
    logic [31:0]         cyc;
  } exp_t;

  exp_t q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [N-1:0][W-1:0] cur = '0;
  int          nb = 0;
  logic        cur_mode = 1'b0;
  logic [7:0]  nid = 8'd0;
  logic        timed = 1'b0;
  int          exp_rerr_total = 0;
  int          exp_ferr_total = 0;
  int          seen_rerr = 0;
  int          seen_ferr = 0;
  logic        ready_watch = 1'b0;
  int          ready_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the oldest expected frame whenever one is handed over
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.range_err) seen_rerr++;
      if (bus.frame_err) seen_ferr++;
      if (ready_watch && !bus.s_ready) ready_drops++;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_frame: got frame id %0d expected none", bus.m_frame_id);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < N; i++) check($sformatf("data[%0d] id%0d", i, e.id), bus.m_data[i], e.data[i]);
          check("m_mode", {31'd0, bus.m_mode}, {31'd0, e.mode});
          check("m_frame_id", {24'd0, bus.m_frame_id}, {24'd0, e.id});
          if (e.timed) begin
            check("latency_cycle", cyc, e.cyc);
            check("frame_err_at_issue", {31'd0, bus.frame_err}, {31'd0, e.ferr});
            check("range_err_at_issue", {31'd0, bus.range_err}, {31'd0, e.rerr});
          end
        end
      end
    end
  end

  // One beat; d is driven, e is the hand-computed stored value
  task automatic beat(input coef_t d, input coef_t e, input logic last, input logic mode, input logic rerr);
    int w;
    exp_t x;
    w = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_mode  = mode;
    @(negedge clk);
    while (!bus.s_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!bus.s_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (nb == 0) cur_mode = mode;
      cur[nb] = e;
      if (rerr) exp_rerr_total++;
      if (last || nb == N - 1) begin
        x.data = cur; x.mode = cur_mode; x.id = nid; x.ferr = !last;
        x.rerr = rerr; x.timed = timed; x.cyc = cyc + 1;
        q.push_back(x);
        if (!last) exp_ferr_total++;
        nid = nid + 8'd1;
        cur = '0;
        nb = 0;
      end else begin
        nb++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_mode  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_mode  = 1'b0;
    bus.m_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("reset_m_data0", bus.m_data[0], 32'd0);
    check("reset_m_mode", {31'd0, bus.m_mode}, 32'd0);
    check("reset_errs", {30'd0, bus.frame_err, bus.range_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: short frame padded with zeros
    timed = 1'b1;
    for (int k = 0; k < 5; k++) beat(123412341 + k, 123412341 + k, k == 4, 1'b0, 1'b0);
    idle();
    drain();

    // 2: reduction corner values
    beat(32'd134221490, 32'd1,         1'b0, 1'b0, 1'b0);
    beat(32'd134221488, 32'd134221488, 1'b0, 1'b0, 1'b0);
    beat(32'd268442978, 32'd134221489, 1'b1, 1'b0, 1'b1);
    idle();
    drain();

    // 3: three back-to-back full frames, s_ready must stay high
    ready_watch = 1'b1;
    for (int k = 0; k < 24; k++) beat(1000 + k, 1000 + k, (k % 8) == 7, (k / 8) == 1, 1'b0);
    ready_watch = 1'b0;
    idle();
    drain();
    check("ready_never_low", ready_drops, 32'd0);

    // 4: backpressure fills both banks
    timed = 1'b0;
    bus.m_ready = 1'b0;
    for (int k = 0; k < 16; k++) beat(5000 + k, 5000 + k, (k % 8) == 7, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("bp_s_ready_low", {31'd0, bus.s_ready}, 32'd0);
    check("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_data0", bus.m_data[0], 32'd5000);
      check("bp_hold_data7", bus.m_data[7], 32'd5007);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("ready_in_issue_cycle", {31'd0, bus.s_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_issue", {31'd0, bus.s_ready}, 32'd1);
    drain();

    // 5: eight beats without s_last, then a beat into the other bank
    timed = 1'b1;
    for (int k = 0; k < 8; k++) beat(9000 + k, 9000 + k, 1'b0, k == 0, 1'b0);
    beat(32'd777, 32'd777, 1'b1, 1'b0, 1'b0);
    idle();
    drain();

    // 6: reset mid-frame discards the partial frame
    for (int k = 0; k < 3; k++) beat(4242 + k, 4242 + k, 1'b0, 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    cur = '0; nb = 0; nid = 8'd0;
    @(negedge clk);
    check("midreset_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("midreset_s_ready", {31'd0, bus.s_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    beat(32'd31, 32'd31, 1'b0, 1'b0, 1'b0);
    beat(32'd32, 32'd32, 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    repeat (3) @(negedge clk);

    check("range_err_pulses", seen_rerr, exp_rerr_total);
    check("frame_err_pulses", seen_ferr, exp_ferr_total);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
